// File: rtl/dvp_pkg.sv
// Shared definitions for the synthetic DVP pattern source: FSM states,
// pattern mode encodings and RGB565 colour-bar constants.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  localparam logic [1:0] MODE_BARS    = 2'd0;
  localparam logic [1:0] MODE_RAMP    = 2'd1;
  localparam logic [1:0] MODE_SOLID   = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // Bar index (0 = leftmost) to RGB565 colour.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational pattern generator: pixel coordinate, byte phase and mode
// in, one RGB565 byte out (high byte in phase 0, low byte in phase 1).
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] x,
  input  logic [4:0]  y,
  input  logic        phase,
  input  logic [1:0]  mode,
  input  logic [15:0] solid,
  output logic [7:0]  data
);

  logic [15:0] pixel;
  logic [2:0]  bar;

  // Select the 16-bit pixel for the current mode, then pick the byte.
  always_comb begin
    bar   = 3'((32'(x) * 32'd8) / 32'(H_ACTIVE));
    pixel = 16'h0000;
    case (mode)
      MODE_BARS:  pixel = bar_color(bar);
      MODE_RAMP:  pixel = {y[4:0], x[5:0], x[4:0]};
      MODE_SOLID: pixel = solid;
      default:    pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
    endcase
    data = phase ? pixel[7:0] : pixel[15:8];
  end

endmodule

// File: rtl/dvp_pattern_source.sv
// Synthetic OV7670-style DVP transmitter. A line/frame FSM walks
// VSYNC -> VBACK -> ACTIVE -> VFRONT; every output is registered one
// cycle after the state/counter values it is derived from.
module dvp_pattern_source
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        busy
);

  localparam int          LINE_LEN    = 2 * (H_ACTIVE + H_BLANK);
  localparam logic [15:0] H_LAST      = 16'(LINE_LEN - 1);
  localparam logic [15:0] H_ACT_BYTES = 16'(2 * H_ACTIVE);
  localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VBACK_LAST  = 16'(V_BACK - 1);
  localparam logic [15:0] ACTIVE_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VFRONT_LAST = 16'(V_FRONT - 1);

  state_e      state, state_nxt;
  logic [15:0] h_cnt, h_nxt;
  logic [15:0] v_cnt, v_nxt;
  logic [1:0]  mode_q, mode_nxt;
  logic [15:0] solid_q, solid_nxt;
  logic        line_end, last_line, frame_end, href_nxt;
  logic [7:0]  pat_byte;

  dvp_pattern_gen #(
    .H_ACTIVE(H_ACTIVE)
  ) u_gen (
    .x    ({1'b0, h_cnt[15:1]}),
    .y    (v_cnt[4:0]),
    .phase(h_cnt[0]),
    .mode (mode_q),
    .solid(solid_q),
    .data (pat_byte)
  );

  // Next-state, counter and frame-config logic.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    mode_nxt  = mode_q;
    solid_nxt = solid_q;
    frame_end = 1'b0;
    line_end  = (h_cnt == H_LAST);
    case (state)
      ST_VSYNC:  last_line = (v_cnt == VSYNC_LAST);
      ST_VBACK:  last_line = (v_cnt == VBACK_LAST);
      ST_ACTIVE: last_line = (v_cnt == ACTIVE_LAST);
      ST_VFRONT: last_line = (v_cnt == VFRONT_LAST);
      default:   last_line = 1'b0;
    endcase

    if (state == ST_IDLE) begin
      h_nxt = 16'd0;
      v_nxt = 16'd0;
      if (enable) begin
        state_nxt = ST_VSYNC;
        mode_nxt  = mode;
        solid_nxt = solid_color;
      end
    end else begin
      h_nxt = line_end ? 16'd0 : h_cnt + 16'd1;
      if (line_end) begin
        if (last_line) begin
          v_nxt = 16'd0;
          case (state)
            ST_VSYNC:  state_nxt = ST_VBACK;
            ST_VBACK:  state_nxt = ST_ACTIVE;
            ST_ACTIVE: state_nxt = ST_VFRONT;
            default: begin
              // End of VFRONT: restart immediately or fall back to IDLE.
              frame_end = 1'b1;
              if (enable) begin
                state_nxt = ST_VSYNC;
                mode_nxt  = mode;
                solid_nxt = solid_color;
              end else begin
                state_nxt = ST_IDLE;
              end
            end
          endcase
        end else begin
          v_nxt = v_cnt + 16'd1;
        end
      end
    end

    href_nxt = (state == ST_ACTIVE) && (h_cnt < H_ACT_BYTES);
  end

  // State, counters, latched frame config and registered outputs.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      h_cnt      <= 16'd0;
      v_cnt      <= 16'd0;
      mode_q     <= MODE_BARS;
      solid_q    <= 16'd0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      mode_q     <= mode_nxt;
      solid_q    <= solid_nxt;
      vsync      <= (state == ST_VSYNC);
      href       <= href_nxt;
      data       <= href_nxt ? pat_byte : 8'd0;
      frame_done <= frame_end;
      busy       <= (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Bench for dvp_pattern_source with a small geometry (L=20, 140-cycle
// frames) plus a standalone table of pattern-generator vectors.
module tb_dvp_pattern_source;

  logic        pclk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        vsync, href, frame_done, busy;
  logic [7:0]  data;

  logic [15:0] g_x;
  logic [4:0]  g_y;
  logic        g_phase;
  logic [1:0]  g_mode;
  logic [15:0] g_solid;
  logic [7:0]  g_data;

  int checks   = 0;
  int failures = 0;

  logic       rec_vs [0:299];
  logic       rec_hr [0:299];
  logic       rec_fd [0:299];
  logic       rec_bz [0:299];
  logic [7:0] rec_d  [0:299];

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] x;
    logic [4:0]  y;
    logic        phase;
    logic [15:0] solid;
    logic [7:0]  want;
  } gvec_t;

  gvec_t gv [13];

  dvp_pattern_source #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(2),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .pclk(pclk), .reset(reset), .enable(enable), .mode(mode),
    .solid_color(solid_color), .vsync(vsync), .href(href),
    .data(data), .frame_done(frame_done), .busy(busy)
  );

  dvp_pattern_gen #(.H_ACTIVE(8)) u_gen (
    .x(g_x), .y(g_y), .phase(g_phase), .mode(g_mode),
    .solid(g_solid), .data(g_data)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting, got none, expected event", name);
  endtask

  function automatic logic [7:0] model_byte(input logic [1:0] m, input logic [15:0] s,
                                            input int x, input int y, input int ph);
    logic [15:0] p;
    case (m)
      2'd0: begin
        case (x)
          0: p = 16'hFFFF;  1: p = 16'hFFE0;  2: p = 16'h07FF;  3: p = 16'h07E0;
          4: p = 16'hF81F;  5: p = 16'hF800;  6: p = 16'h001F;  default: p = 16'h0000;
        endcase
      end
      2'd1:    p = {y[4:0], x[5:0], x[4:0]};
      2'd2:    p = s;
      default: p = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
    endcase
    return (ph != 0) ? p[7:0] : p[15:8];
  endfunction

  task automatic wait_vsync(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk);
      if (vsync) begin
        ok = 1'b1;
        return;
      end
    end
    timeout("vsync_start");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk);
      if (!busy) return;
    end
    timeout("busy_fall");
  endtask

  // Sample n cycles starting at the current negedge (vsync just rose).
  task automatic record(input int n, input int drop_at, input int chg_at);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge pclk);
      rec_vs[i] = vsync;
      rec_hr[i] = href;
      rec_fd[i] = frame_done;
      rec_bz[i] = busy;
      rec_d[i]  = data;
      if (i == drop_at) enable = 1'b0;
      if (i == chg_at) begin
        solid_color = 16'hABCD;
        mode        = 2'd0;
      end
    end
  endtask

  // Compare one recorded 140-cycle frame against the timing/pattern model.
  task automatic check_frame(input string tag, input logic [1:0] m, input logic [15:0] s);
    int vs_err = 0, hr_err = 0, d_err = 0, fd_err = 0;
    for (int c = 0; c < 140; c++) begin
      logic exp_hr;
      logic [7:0] exp_d;
      exp_hr = (c >= 40) && (c < 120) && (((c - 40) % 20) < 16);
      exp_d  = 8'h00;
      if (exp_hr)
        exp_d = model_byte(m, s, ((c - 40) % 20) / 2, (c - 40) / 20, (c - 40) % 2);
      if (rec_vs[c] !== (c < 20)) vs_err++;
      if (rec_hr[c] !== exp_hr) hr_err++;
      if (rec_fd[c] !== (c == 139)) fd_err++;
      if (rec_d[c] !== exp_d) d_err++;
    end
    chk({tag, "_vsync_errs"}, vs_err, 0);
    chk({tag, "_href_errs"}, hr_err, 0);
    chk({tag, "_frame_done_errs"}, fd_err, 0);
    chk({tag, "_data_errs"}, d_err, 0);
  endtask

  initial begin
    bit ok;
    int hr_cnt, vs_first, hr_first, vs_before;
    logic [7:0] bars_exp [16];
    bars_exp = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    gv[0]  = '{2'd0, 16'd0,    5'd0,  1'b0, 16'h0000, 8'hFF};
    gv[1]  = '{2'd0, 16'd1,    5'd0,  1'b1, 16'h0000, 8'hE0};
    gv[2]  = '{2'd0, 16'd4,    5'd0,  1'b0, 16'h0000, 8'hF8};
    gv[3]  = '{2'd0, 16'd6,    5'd0,  1'b1, 16'h0000, 8'h1F};
    gv[4]  = '{2'd0, 16'd7,    5'd0,  1'b0, 16'h0000, 8'h00};
    gv[5]  = '{2'd1, 16'd5,    5'd3,  1'b0, 16'h0000, 8'h18};
    gv[6]  = '{2'd1, 16'd5,    5'd3,  1'b1, 16'h0000, 8'hA5};
    gv[7]  = '{2'd1, 16'h002A, 5'h11, 1'b0, 16'h0000, 8'h8D};
    gv[8]  = '{2'd2, 16'd3,    5'd2,  1'b0, 16'hBEEF, 8'hBE};
    gv[9]  = '{2'd2, 16'd3,    5'd2,  1'b1, 16'hBEEF, 8'hEF};
    gv[10] = '{2'd3, 16'd8,    5'd0,  1'b0, 16'h0000, 8'hFF};
    gv[11] = '{2'd3, 16'd8,    5'd8,  1'b0, 16'h0000, 8'h00};
    gv[12] = '{2'd3, 16'd0,    5'd8,  1'b1, 16'h0000, 8'hFF};

    reset = 1'b1; enable = 1'b0; mode = 2'd0; solid_color = 16'h0000;
    g_x = 16'd0; g_y = 5'd0; g_phase = 1'b0; g_mode = 2'd0; g_solid = 16'd0;
    repeat (3) @(negedge pclk);
    chk("reset_vsync", vsync, 0);
    chk("reset_href", href, 0);
    chk("reset_data", data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);

    for (int i = 0; i < 13; i++) begin
      g_mode = gv[i].mode; g_x = gv[i].x; g_y = gv[i].y;
      g_phase = gv[i].phase; g_solid = gv[i].solid;
      #1;
      chk($sformatf("gen_vec%0d", i), g_data, gv[i].want);
    end

    @(negedge pclk) reset = 1'b0;
    @(negedge pclk);

    // Colour bars, enable held so the next frame follows immediately.
    mode = 2'd0; enable = 1'b1;
    wait_vsync(ok);
    if (ok) begin
      record(141, -1, -1);
      check_frame("bars", 2'd0, 16'h0000);
      for (int i = 0; i < 16; i++) chk($sformatf("bars_line0_byte%0d", i), rec_d[40 + i], bars_exp[i]);
      chk("bars_busy_end", rec_bz[139], 1);
      chk("bars_restart_vsync", rec_vs[140], 1);
    end
    enable = 1'b0;
    wait_idle();

    // Solid colour; config changes mid-frame must not take effect, enable dropped at 50.
    mode = 2'd2; solid_color = 16'h1234; enable = 1'b1;
    wait_vsync(ok);
    if (ok) begin
      record(170, 50, 60);
      check_frame("solid", 2'd2, 16'h1234);
      chk("solid_first_hi", rec_d[40], 8'h12);
      chk("solid_first_lo", rec_d[41], 8'h34);
      chk("solid_busy_at_done", rec_bz[139], 1);
      chk("solid_busy_after_done", rec_bz[140], 0);
      hr_cnt = 0;
      for (int c = 140; c < 170; c++) hr_cnt += int'(rec_vs[c]) + int'(rec_bz[c]);
      chk("solid_stays_idle", hr_cnt, 0);
    end

    // Ramp.
    mode = 2'd1; solid_color = 16'h0000; enable = 1'b1;
    wait_vsync(ok);
    if (ok) begin
      record(140, 0, -1);
      check_frame("ramp", 2'd1, 16'h0000);
      chk("ramp_y3_x5_hi", rec_d[110], 8'h18);
      chk("ramp_y3_x5_lo", rec_d[111], 8'hA5);
    end
    wait_idle();

    // Checker: 32 pixels (64 href bytes) per frame.
    mode = 2'd3; enable = 1'b1;
    wait_vsync(ok);
    if (ok) begin
      record(140, 0, -1);
      check_frame("checker", 2'd3, 16'h0000);
      hr_cnt = 0;
      for (int c = 0; c < 140; c++) hr_cnt += int'(rec_hr[c]);
      chk("checker_href_bytes", hr_cnt, 64);
    end
    wait_idle();

    // Reset during ACTIVE, then a full VSYNC must precede the next href.
    mode = 2'd0; enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge pclk);
      if (href) ok = 1'b1;
    end
    if (!ok) timeout("href_before_reset");
    reset = 1'b1;
    #1;
    chk("rst_mid_vsync", vsync, 0);
    chk("rst_mid_href", href, 0);
    chk("rst_mid_data", data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_frame_done", frame_done, 0);
    @(negedge pclk) reset = 1'b0;
    vs_first = -1; hr_first = -1; vs_before = 0;
    for (int i = 0; i < 300 && hr_first < 0; i++) begin
      @(negedge pclk);
      if (vsync && vs_first < 0) vs_first = i;
      if (vsync) vs_before++;
      if (href) hr_first = i;
    end
    if (hr_first < 0 || vs_first < 0) begin
      timeout("restart_after_reset");
    end else begin
      chk("restart_href_delay", hr_first - vs_first, 40);
      chk("restart_vsync_len", vs_before, 20);
    end
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
